ixc_sfifo_port_mw: RTL
======================

// Module: ixc_sfifo_port_mw
// PURPOSE
//  Parametrised successor of the single-beat SFIFO call port. Receives multi-beat argument packets from the
//  512b channel bus, filters them by transaction ID, assembles IARG_W-bit arguments and buffers up to DEPTH
//  calls for the emulated consumer. Returns OARG_W-bit results onto the channel output bus.
//  Sits between the channel transport and a DPI/SFIFO call site; one instance per call site.
// PARAMETERS
//  IARG_W  1024  argument width in bits; BEATS = ceil(IARG_W/BUS_W) (1..8)
//  OARG_W  32    result width in bits (1..BUS_W)
//  BUS_W   512   channel data width
//  TID_W   22    transaction ID width
//  DEPTH   4     assembled-argument buffer entries, power of 2 (>=2)
// PORTS
//  fclk        in   1       emulation fast clock; all state on rising edge
//  GFReset     in   1       asynchronous, active-high reset
//  tid         in   TID_W   this port's transaction ID (static)
//  CiValid     in   1       input beat valid
//  CiData      in   BUS_W   input beat data
//  CtId        in   TID_W   input beat transaction ID
//  CiReady     out  1       port can accept a beat addressed to tid
//  fen         out  1       buffer not full (flow enable to upstream scheduler)
//  call        out  1       head entry valid (call pending)
//  iarg        out  IARG_W  head entry argument
//  call_ack    in   1       consumer pops head entry
//  oarg_valid  in   1       consumer result valid (one cycle)
//  oarg        in   OARG_W  consumer result
//  CoData      out  BUS_W   result beat, oarg zero-extended
//  CoDataEn    out  1       result beat valid (one-cycle pulse)
//  CoDataLen   out  4       result length in 32b words minus 1 = ceil(OARG_W/32)-1
// BEHAVIOUR
//  Reset: count/pointers/beat index=0; call=0, CiReady=1, fen=1, CoDataEn=0, CoData=0, CoDataLen=0.
//   Partially assembled packet discarded; buffer contents don't-care.
//  Accept: beat taken iff CiValid & (CtId==tid) & CiReady. Beats with other IDs ignored, do not disturb
//   assembly. Beat k (0..BEATS-1) writes iarg bits [k*BUS_W +: BUS_W] of write entry; final beat
//   truncated to IARG_W.
//  Commit: on accepting beat BEATS-1, entry made visible next cycle (call rises 1 cycle after last beat);
//   beat index returns to 0; write pointer wraps mod DEPTH.
//  CiReady = fen = (count < DEPTH); registered, derived from state. Backpressure may stall a packet
//   mid-stream; assembly resumes at the held beat index.
//  Pop: call_ack while call=1 advances read pointer; next entry (if any) presented next cycle.
//   call_ack while call=0 ignored. iarg stable while call=1 and no ack.
//  Commit and pop in same cycle: count unchanged; full stays full only if count was DEPTH before.
//  Full: count==DEPTH -> CiReady=0; a beat with valid ID is not accepted and must be held upstream.
//  Return path: oarg_valid -> next cycle CoDataEn=1 for exactly one cycle, CoData={0,oarg}, CoDataLen const.
//   Back-to-back oarg_valid yields back-to-back pulses; CoData holds last value when CoDataEn=0.
//  count width clog2(DEPTH)+1; pointers clog2(DEPTH), natural wrap. No overflow/underflow possible.
// STRUCTURE
//  Shared package ixc_sfifo_pkg: CHAN_BUS_W=512, CHAN_TID_W=22, CHAN_LEN_W=4, function beats(w,bus).
//  One sub-module: ixc_sfifo_argbuf (DEPTH x IARG_W storage + pointers/count, push/pop/full/empty).
//  Top holds ID compare, beat assembler, return-path register.
// TESTING
//  1 Single call: BEATS=2, tid=0x2A; beats 0x11.., 0x22.. with CtId=0x2A -> call=1 cycle after beat 1,
//    iarg={0x22..,0x11..}; call_ack -> call=0 next cycle.
//  2 ID filter: interleave beat with CtId=0x2B between the two 0x2A beats -> ignored, iarg as test 1.
//  3 Full: DEPTH=4, push 5 packets without ack -> CiReady/fen=0 after 4th commit, 5th held;
//    one ack -> 5th accepted, total 5 calls in order.
//  4 Simultaneous: count=2, commit and call_ack same cycle -> count stays 2, order preserved.
//  5 Reset mid-packet: GFReset after beat 0 -> call=0, CiReady=1; next full packet assembles from beat 0.
//  6 Return: oarg_valid with oarg=0xDEADBEEF, OARG_W=32 -> next cycle CoDataEn=1, CoData=0x..DEADBEEF,
//    CoDataLen=0; two consecutive valids -> two consecutive pulses.

Source files
------------

// File: rtl/ixc_sfifo_pkg.sv
// Channel-bus constants and sizing helpers shared by the SFIFO call-port family.
package ixc_sfifo_pkg;

    localparam int CHAN_BUS_W = 512;
    localparam int CHAN_TID_W = 22;
    localparam int CHAN_LEN_W = 4;

    // Number of bus beats needed to carry a w-bit argument.
    function automatic int beats(input int w, input int bus);
        return (w + bus - 1) / bus;
    endfunction

    // Index width that stays legal (>=1) even for a single-beat argument.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Result length in 32-bit words minus one, as carried on CoDataLen.
    function automatic int words32_m1(input int w);
        return (w + 31) / 32 - 1;
    endfunction

endpackage

// File: rtl/ixc_sfifo_port_mw_if.sv
// Channel/consumer handshake bundle of the multi-beat SFIFO call port; slave is the port, master drives it.
interface ixc_sfifo_port_mw_if #(
    parameter int IARG_W = 1024,
    parameter int OARG_W = 32,
    parameter int BUS_W  = ixc_sfifo_pkg::CHAN_BUS_W,
    parameter int TID_W  = ixc_sfifo_pkg::CHAN_TID_W
);

    logic                                CiValid;
    logic [BUS_W-1:0]                    CiData;
    logic [TID_W-1:0]                    CtId;
    logic                                CiReady;
    logic                                fen;
    logic                                call;
    logic [IARG_W-1:0]                   iarg;
    logic                                call_ack;
    logic                                oarg_valid;
    logic [OARG_W-1:0]                   oarg;
    logic [BUS_W-1:0]                    CoData;
    logic                                CoDataEn;
    logic [ixc_sfifo_pkg::CHAN_LEN_W-1:0] CoDataLen;

    modport slave (
        input  CiValid, CiData, CtId, call_ack, oarg_valid, oarg,
        output CiReady, fen, call, iarg, CoData, CoDataEn, CoDataLen
    );

    modport master (
        output CiValid, CiData, CtId, call_ack, oarg_valid, oarg,
        input  CiReady, fen, call, iarg, CoData, CoDataEn, CoDataLen
    );

endinterface

// File: rtl/ixc_sfifo_argbuf.sv
// DEPTH-entry argument store written beat-by-beat into the tail entry; push commits it, pop retires the head.
// Head data and flags are visible the cycle after the push/pop edge; full is a registered flag.
module ixc_sfifo_argbuf
    import ixc_sfifo_pkg::*;
#(
    parameter int  IARG_W = 1024,
    parameter int  BUS_W  = CHAN_BUS_W,
    parameter int  DEPTH  = 4,
    localparam int BEATS  = beats(IARG_W, BUS_W),
    localparam int BI_W   = idx_w(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BI_W-1:0]   wr_beat,
    input  logic [BUS_W-1:0]  wr_dat,
    input  logic              push,
    input  logic              pop,
    output logic [IARG_W-1:0] rd_dat,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int MEM_W = BEATS * BUS_W;

    logic [MEM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             full_q;

    always_comb begin
        count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_q <= (count_nxt == (PTR_W+1)'(DEPTH));
        end
    end

    // The tail entry is invisible until push, so beats land in place with no staging register.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr][int'(wr_beat) * BUS_W +: BUS_W] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr][IARG_W-1:0];
    assign full   = full_q;
    assign empty  = (count == '0);

endmodule

// File: rtl/ixc_sfifo_port_mw.sv
// Multi-beat SFIFO call port: ID-filtered beat assembly into a DEPTH-deep call buffer, plus a one-cycle result return.
// call rises one cycle after the last beat; CiReady/fen drop while the buffer is full and the held beat waits upstream.
module ixc_sfifo_port_mw
    import ixc_sfifo_pkg::*;
#(
    parameter int IARG_W = 1024,
    parameter int OARG_W = 32,
    parameter int BUS_W  = CHAN_BUS_W,
    parameter int TID_W  = CHAN_TID_W,
    parameter int DEPTH  = 4
) (
    input  logic             fclk,
    input  logic             GFReset,
    input  logic [TID_W-1:0] tid,
    ixc_sfifo_port_mw_if.slave bus
);

    localparam int BEATS = beats(IARG_W, BUS_W);
    localparam int BI_W  = idx_w(BEATS);
    localparam int LEN   = words32_m1(OARG_W);

    logic              full;
    logic              empty;
    logic              take;
    logic              last;
    logic              pop;
    logic [BI_W-1:0]   beat_idx;
    logic [IARG_W-1:0] head_dat;
    logic [BUS_W-1:0]  oarg_ext;
    logic [BUS_W-1:0]  co_dat;
    logic              co_en;

    assign take = bus.CiValid && (bus.CtId == tid) && !full;
    assign last = take && (beat_idx == BI_W'(BEATS - 1));
    assign pop  = bus.call_ack && !empty;

    // Foreign-ID beats and stalls leave beat_idx alone, so assembly resumes where it stopped.
    always_ff @(posedge fclk or posedge GFReset) begin
        if (GFReset) begin
            beat_idx <= '0;
        end else if (take) begin
            beat_idx <= last ? '0 : beat_idx + 1'b1;
        end
    end

    ixc_sfifo_argbuf #(
        .IARG_W (IARG_W),
        .BUS_W  (BUS_W),
        .DEPTH  (DEPTH)
    ) u_argbuf (
        .clk     (fclk),
        .rst     (GFReset),
        .wr_en   (take),
        .wr_beat (beat_idx),
        .wr_dat  (bus.CiData),
        .push    (last),
        .pop     (pop),
        .rd_dat  (head_dat),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        oarg_ext                = '0;
        oarg_ext[OARG_W-1:0]    = bus.oarg;
    end

    always_ff @(posedge fclk or posedge GFReset) begin
        if (GFReset) begin
            co_en  <= 1'b0;
            co_dat <= '0;
        end else begin
            co_en <= bus.oarg_valid;
            if (bus.oarg_valid) co_dat <= oarg_ext;
        end
    end

    assign bus.CiReady   = !full;
    assign bus.fen       = !full;
    assign bus.call      = !empty;
    assign bus.iarg      = head_dat;
    assign bus.CoData    = co_dat;
    assign bus.CoDataEn  = co_en;
    assign bus.CoDataLen = CHAN_LEN_W'(LEN);

endmodule
